// File: rtl/i2c_txn_scheduler.sv
// ---------------------------------------------------------------------------
// i2c_txn_scheduler
//
// Shares one byte-level I2C master engine between N_REQ requesters. Each
// requester submits a single-register transaction (write or read, 7-bit
// device address, 8-bit register address). A round-robin arbiter picks one
// requester. The winner's transaction is turned into a stream of engine
// commands (START / WRITE / READ / STOP). Exactly one response is returned
// per accepted request. Lost arbitration is retried up to MAX_RETRY times.
//
// Ports
//   clk_i, rst_i (async, active-high), srst_i (sync, active-high)
//   req_valid_i/req_ready_o    per-requester handshake (ready is a 1-cycle
//                              one-hot accept pulse)
//   req_rnw_i/req_dev_i/req_reg_i/req_wdata_i
//                              per-requester transaction fields, packed by index
//   rsp_valid_o/rsp_id_o/rsp_rdata_o/rsp_status_o
//                              1-cycle response (status 0=OK 1=NACK 2=ARB)
//   cmd_valid_o/cmd_ready_i/cmd_op_o/cmd_data_o/cmd_nack_o
//                              engine command channel
//   done_i/done_ack_i/done_arblost_i/done_rdata_i
//                              engine completion for the last accepted command
// ---------------------------------------------------------------------------
module i2c_txn_scheduler #(
  parameter int N_REQ     = 4,
  parameter int MAX_RETRY = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       srst_i,
  input  logic [N_REQ-1:0]           req_valid_i,
  output logic [N_REQ-1:0]           req_ready_o,
  input  logic [N_REQ-1:0]           req_rnw_i,
  input  logic [7*N_REQ-1:0]         req_dev_i,
  input  logic [8*N_REQ-1:0]         req_reg_i,
  input  logic [8*N_REQ-1:0]         req_wdata_i,
  output logic                       rsp_valid_o,
  output logic [$clog2(N_REQ)-1:0]   rsp_id_o,
  output logic [7:0]                 rsp_rdata_o,
  output logic [1:0]                 rsp_status_o,
  output logic                       cmd_valid_o,
  input  logic                       cmd_ready_i,
  output logic [1:0]                 cmd_op_o,
  output logic [7:0]                 cmd_data_o,
  output logic                       cmd_nack_o,
  input  logic                       done_i,
  input  logic                       done_ack_i,
  input  logic                       done_arblost_i,
  input  logic [7:0]                 done_rdata_i
);

  localparam int IDW = $clog2(N_REQ);
  localparam int RW  = $clog2(MAX_RETRY + 2);

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_STOP  = 2'd3;

  localparam logic [1:0] ST_OK   = 2'd0;
  localparam logic [1:0] ST_NACK = 2'd1;
  localparam logic [1:0] ST_ARB  = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE, S_GRANT, S_START, S_DEV_W, S_REG, S_WDATA,
    S_RSTART, S_DEV_R, S_RDATA, S_STOP, S_RESP
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_wait,  w_wait_nxt;
  logic [IDW-1:0]   r_id,    w_id_nxt;
  logic             r_rnw,   w_rnw_nxt;
  logic [6:0]       r_dev,   w_dev_nxt;
  logic [7:0]       r_reg,   w_reg_nxt;
  logic [7:0]       r_wdata, w_wdata_nxt;
  logic [IDW-1:0]   r_ptr,   w_ptr_nxt;
  logic [RW-1:0]    r_retry, w_retry_nxt;
  logic [1:0]       r_status, w_status_nxt;
  logic [7:0]       r_rdata, w_rdata_nxt;

  logic             w_found;
  logic [IDW-1:0]   w_win;

  // Per-requester field views so the winner can be selected by index.
  logic [6:0] w_dev_arr   [N_REQ];
  logic [7:0] w_reg_arr   [N_REQ];
  logic [7:0] w_wdata_arr [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign w_dev_arr[k]   = req_dev_i[7*k +: 7];
    assign w_reg_arr[k]   = req_reg_i[8*k +: 8];
    assign w_wdata_arr[k] = req_wdata_i[8*k +: 8];
  end

  // Round-robin search: walk from the pointer, wrapping at N_REQ, and take
  // the first requester that is valid.
  always_comb begin
    logic [IDW-1:0] idx;
    w_found = 1'b0;
    w_win   = '0;
    idx     = r_ptr;
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && req_valid_i[idx]) begin
        w_found = 1'b1;
        w_win   = idx;
      end
      idx = (idx == IDW'(N_REQ - 1)) ? '0 : idx + 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_wait   <= 1'b0;
      r_id     <= '0;
      r_rnw    <= 1'b0;
      r_dev    <= '0;
      r_reg    <= '0;
      r_wdata  <= '0;
      r_ptr    <= '0;
      r_retry  <= '0;
      r_status <= ST_OK;
      r_rdata  <= '0;
    end else if (srst_i) begin
      r_state  <= S_IDLE;
      r_wait   <= 1'b0;
      r_id     <= '0;
      r_rnw    <= 1'b0;
      r_dev    <= '0;
      r_reg    <= '0;
      r_wdata  <= '0;
      r_ptr    <= '0;
      r_retry  <= '0;
      r_status <= ST_OK;
      r_rdata  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_wait   <= w_wait_nxt;
      r_id     <= w_id_nxt;
      r_rnw    <= w_rnw_nxt;
      r_dev    <= w_dev_nxt;
      r_reg    <= w_reg_nxt;
      r_wdata  <= w_wdata_nxt;
      r_ptr    <= w_ptr_nxt;
      r_retry  <= w_retry_nxt;
      r_status <= w_status_nxt;
      r_rdata  <= w_rdata_nxt;
    end
  end

  // Next-state logic. Every command state has two phases tracked by r_wait:
  // phase 0 presents the command until the engine accepts it, phase 1 waits
  // for done_i. done_i outside phase 1 has nothing to complete and is ignored.
  always_comb begin
    w_state_nxt  = r_state;
    w_wait_nxt   = r_wait;
    w_id_nxt     = r_id;
    w_rnw_nxt    = r_rnw;
    w_dev_nxt    = r_dev;
    w_reg_nxt    = r_reg;
    w_wdata_nxt  = r_wdata;
    w_ptr_nxt    = r_ptr;
    w_retry_nxt  = r_retry;
    w_status_nxt = r_status;
    w_rdata_nxt  = r_rdata;

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_GRANT;
          w_id_nxt    = w_win;
          w_rnw_nxt   = req_rnw_i[w_win];
          w_dev_nxt   = w_dev_arr[w_win];
          w_reg_nxt   = w_reg_arr[w_win];
          w_wdata_nxt = w_wdata_arr[w_win];
          w_ptr_nxt   = (w_win == IDW'(N_REQ - 1)) ? '0 : w_win + 1'b1;
        end
      end

      S_GRANT: begin
        w_state_nxt  = S_START;
        w_wait_nxt   = 1'b0;
        w_retry_nxt  = '0;
        w_status_nxt = ST_OK;
        w_rdata_nxt  = '0;
      end

      S_RESP: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        if (!r_wait) begin
          if (cmd_ready_i) begin
            w_wait_nxt = 1'b1;
          end
        end else if (done_i) begin
          w_wait_nxt = 1'b0;
          if (done_arblost_i) begin
            // The bus is no longer ours, so no STOP is sent; either start over
            // or give up once the retry budget is spent.
            if (r_retry < RW'(MAX_RETRY)) begin
              w_retry_nxt  = r_retry + 1'b1;
              w_state_nxt  = S_START;
              w_status_nxt = ST_OK;
              w_rdata_nxt  = '0;
            end else begin
              w_status_nxt = ST_ARB;
              w_state_nxt  = S_RESP;
            end
          end else begin
            case (r_state)
              S_START:  w_state_nxt = S_DEV_W;
              S_DEV_W: begin
                if (done_ack_i) begin
                  w_state_nxt = S_REG;
                end else begin
                  w_state_nxt  = S_STOP;
                  w_status_nxt = ST_NACK;
                end
              end
              S_REG: begin
                if (!done_ack_i) begin
                  w_state_nxt  = S_STOP;
                  w_status_nxt = ST_NACK;
                end else if (r_rnw) begin
                  w_state_nxt = S_RSTART;
                end else begin
                  w_state_nxt = S_WDATA;
                end
              end
              S_WDATA: begin
                w_state_nxt = S_STOP;
                if (!done_ack_i) begin
                  w_status_nxt = ST_NACK;
                end
              end
              S_RSTART: w_state_nxt = S_DEV_R;
              S_DEV_R: begin
                if (done_ack_i) begin
                  w_state_nxt = S_RDATA;
                end else begin
                  w_state_nxt  = S_STOP;
                  w_status_nxt = ST_NACK;
                end
              end
              S_RDATA: begin
                w_rdata_nxt = done_rdata_i;
                w_state_nxt = S_STOP;
              end
              S_STOP:   w_state_nxt = S_RESP;
              default:  w_state_nxt = S_IDLE;
            endcase
          end
        end
      end
    endcase
  end

  // Outputs decoded from the registered state; everything reads zero when
  // idle, which also gives all-zero outputs straight out of reset.
  always_comb begin
    req_ready_o  = '0;
    rsp_valid_o  = 1'b0;
    rsp_id_o     = '0;
    rsp_rdata_o  = '0;
    rsp_status_o = ST_OK;
    cmd_valid_o  = 1'b0;
    cmd_op_o     = OP_START;
    cmd_data_o   = '0;
    cmd_nack_o   = 1'b0;

    if (r_state == S_GRANT) begin
      req_ready_o = {{(N_REQ-1){1'b0}}, 1'b1} << r_id;
    end

    if (r_state == S_RESP) begin
      rsp_valid_o  = 1'b1;
      rsp_id_o     = r_id;
      rsp_status_o = r_status;
      if (r_rnw && (r_status == ST_OK)) begin
        rsp_rdata_o = r_rdata;
      end
    end

    if (!r_wait) begin
      case (r_state)
        S_START, S_RSTART: begin
          cmd_valid_o = 1'b1;
          cmd_op_o    = OP_START;
        end
        S_DEV_W: begin
          cmd_valid_o = 1'b1;
          cmd_op_o    = OP_WRITE;
          cmd_data_o  = {r_dev, 1'b0};
        end
        S_REG: begin
          cmd_valid_o = 1'b1;
          cmd_op_o    = OP_WRITE;
          cmd_data_o  = r_reg;
        end
        S_WDATA: begin
          cmd_valid_o = 1'b1;
          cmd_op_o    = OP_WRITE;
          cmd_data_o  = r_wdata;
        end
        S_DEV_R: begin
          cmd_valid_o = 1'b1;
          cmd_op_o    = OP_WRITE;
          cmd_data_o  = {r_dev, 1'b1};
        end
        S_RDATA: begin
          cmd_valid_o = 1'b1;
          cmd_op_o    = OP_READ;
          cmd_nack_o  = 1'b1;
        end
        S_STOP: begin
          cmd_valid_o = 1'b1;
          cmd_op_o    = OP_STOP;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_scheduler.sv
// ---------------------------------------------------------------------------
// tb_i2c_txn_scheduler
//
// Directed bench for i2c_txn_scheduler. A behavioural engine answers every
// accepted command with a done pulse one cycle later and logs the command
// stream; each scenario compares that log and the response against values
// written out by hand.
// ---------------------------------------------------------------------------
module tb_i2c_txn_scheduler;

  localparam int N_REQ = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        srst_i = 1'b0;
  logic [3:0]  req_valid_i = '0;
  logic [3:0]  req_ready_o;
  logic [3:0]  req_rnw_i = '0;
  logic [27:0] req_dev_i = '0;
  logic [31:0] req_reg_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        rsp_valid_o;
  logic [1:0]  rsp_id_o;
  logic [7:0]  rsp_rdata_o;
  logic [1:0]  rsp_status_o;
  logic        cmd_valid_o;
  logic        cmd_ready_i = 1'b1;
  logic [1:0]  cmd_op_o;
  logic [7:0]  cmd_data_o;
  logic        cmd_nack_o;
  logic        done_i = 1'b0;
  logic        done_ack_i = 1'b0;
  logic        done_arblost_i = 1'b0;
  logic [7:0]  done_rdata_i = '0;

  int vecCount = 0;
  int failCount = 0;
  int rspCount = 0;

  // Engine model controls.
  bit          engFlush = 1'b0;
  bit          engKick = 1'b0;
  bit          engPending = 1'b0;
  bit          engArbStart = 1'b0;
  bit          engNackEn = 1'b0;
  logic [7:0]  engNackByte = '0;
  logic [7:0]  engRdata = '0;
  logic [7:0]  engData = '0;
  logic [1:0]  engOp = '0;
  int          engHoldAfter = 0;
  logic [31:0] cmdLog[$];
  logic [31:0] expQ[$];

  i2c_txn_scheduler #(.N_REQ(4), .MAX_RETRY(3)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .srst_i         (srst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_rnw_i      (req_rnw_i),
    .req_dev_i      (req_dev_i),
    .req_reg_i      (req_reg_i),
    .req_wdata_i    (req_wdata_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_id_o       (rsp_id_o),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_status_o   (rsp_status_o),
    .cmd_valid_o    (cmd_valid_o),
    .cmd_ready_i    (cmd_ready_i),
    .cmd_op_o       (cmd_op_o),
    .cmd_data_o     (cmd_data_o),
    .cmd_nack_o     (cmd_nack_o),
    .done_i         (done_i),
    .done_ack_i     (done_ack_i),
    .done_arblost_i (done_arblost_i),
    .done_rdata_i   (done_rdata_i)
  );

  // Free-running 100 MHz clock.
  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mk(input logic [1:0] op, input logic nack, input logic [7:0] d);
    return {21'd0, op, nack, d};
  endfunction

  function automatic logic [31:0] allOut();
    return 32'({req_ready_o, rsp_valid_o, rsp_id_o, rsp_rdata_o, rsp_status_o,
                cmd_valid_o, cmd_op_o, cmd_data_o, cmd_nack_o});
  endfunction

  // Engine model: a command seen valid at a falling edge is accepted at the
  // next rising edge and completed with a done pulse one cycle later.
  always @(negedge clk_i) begin
    done_i = 1'b0;
    done_ack_i = 1'b0;
    done_arblost_i = 1'b0;
    done_rdata_i = '0;
    if (engFlush) begin
      engPending = 1'b0;
      cmdLog.delete();
      engFlush = 1'b0;
    end else begin
      if (engKick) begin
        done_i = 1'b1;
        done_ack_i = 1'b1;
        engKick = 1'b0;
      end
      if (engPending) begin
        engPending = 1'b0;
        if (!(engHoldAfter != 0 && cmdLog.size() >= engHoldAfter)) begin
          done_i = 1'b1;
          case (engOp)
            2'd0: done_arblost_i = engArbStart;
            2'd1: done_ack_i = !(engNackEn && engData == engNackByte);
            2'd2: done_rdata_i = engRdata;
            default: begin
            end
          endcase
        end
      end
      if (cmd_valid_o && cmd_ready_i && !rst_i && !srst_i) begin
        cmdLog.push_back(mk(cmd_op_o, cmd_nack_o, cmd_data_o));
        engPending = 1'b1;
        engOp = cmd_op_o;
        engData = cmd_data_o;
      end
    end
  end

  // Response pulse counter.
  always @(negedge clk_i) begin
    if (rsp_valid_o) rspCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkSeq(input string tag);
    checkOutput({tag, " cmd count"}, 32'(cmdLog.size()), 32'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < cmdLog.size(); i++) begin
      checkOutput($sformatf("%s cmd%0d", tag, i), cmdLog[i], expQ[i]);
    end
    expQ.delete();
  endtask

  task automatic eS(); expQ.push_back(mk(2'd0, 1'b0, 8'h00)); endtask
  task automatic eW(input logic [7:0] d); expQ.push_back(mk(2'd1, 1'b0, d)); endtask
  task automatic eR(); expQ.push_back(mk(2'd2, 1'b1, 8'h00)); endtask
  task automatic eP(); expQ.push_back(mk(2'd3, 1'b0, 8'h00)); endtask

  task automatic flushLog();
    engFlush = 1'b1;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic resetDut(input bit useSync);
    @(negedge clk_i);
    if (useSync) srst_i = 1'b1;
    else rst_i = 1'b1;
    req_valid_i = '0;
    engArbStart = 1'b0;
    engNackEn = 1'b0;
    engHoldAfter = 0;
    engRdata = '0;
    engFlush = 1'b1;
    repeat (2) @(negedge clk_i);
    checkOutput(useSync ? "srst outputs" : "rst outputs", allOut(), 32'd0);
    srst_i = 1'b0;
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  // Presents one request, waits for its grant and its response.
  task automatic applyStimulus(input int id, input logic rnw, input logic [6:0] dev,
                               input logic [7:0] rg, input logic [7:0] wd, input string tag,
                               output logic [1:0] rid, output logic [1:0] st, output logic [7:0] rd);
    int n;
    req_rnw_i[id] = rnw;
    req_dev_i[7*id +: 7] = dev;
    req_reg_i[8*id +: 8] = rg;
    req_wdata_i[8*id +: 8] = wd;
    req_valid_i[id] = 1'b1;
    n = 0;
    @(negedge clk_i);
    while (req_ready_o == '0 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput({tag, " grant"}, 32'(req_ready_o), 32'd1 << id);
    req_valid_i[id] = 1'b0;
    n = 0;
    while (!rsp_valid_o && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput({tag, " rsp valid"}, 32'(rsp_valid_o), 32'd1);
    rid = rsp_id_o;
    st = rsp_status_o;
    rd = rsp_rdata_o;
    @(negedge clk_i);
  endtask

  initial begin
    logic [1:0] rid;
    logic [1:0] st;
    logic [7:0] rd;
    logic [3:0] grants [4];
    int gcount;
    int n;
    int rspBefore;
    bit saw2;

    // Power-on reset.
    repeat (2) @(negedge clk_i);
    checkOutput("por outputs", allOut(), 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // 1: req0 write dev 0x50 reg 0x10 data 0xA5.
    flushLog();
    applyStimulus(0, 1'b0, 7'h50, 8'h10, 8'hA5, "t1", rid, st, rd);
    eS(); eW(8'hA0); eW(8'h10); eW(8'hA5); eP();
    checkSeq("t1");
    checkOutput("t1 rsp id", 32'(rid), 32'd0);
    checkOutput("t1 rsp status", 32'(st), 32'd0);
    checkOutput("t1 rsp rdata", 32'(rd), 32'd0);

    // 2: req2 read dev 0x50 reg 0x03, engine returns 0x5C.
    flushLog();
    engRdata = 8'h5C;
    applyStimulus(2, 1'b1, 7'h50, 8'h03, 8'h00, "t2", rid, st, rd);
    eS(); eW(8'hA0); eW(8'h03); eS(); eW(8'hA1); eR(); eP();
    checkSeq("t2");
    checkOutput("t2 rsp id", 32'(rid), 32'd2);
    checkOutput("t2 rsp status", 32'(st), 32'd0);
    checkOutput("t2 rsp rdata", 32'(rd), 32'h5C);

    // 3: requesters 0, 1, 3 held valid from a (synchronous) reset.
    resetDut(1'b1);
    for (int k = 0; k < 4; k++) begin
      req_rnw_i[k] = 1'b0;
      req_dev_i[7*k +: 7] = 7'h20 + 7'(k);
      req_reg_i[8*k +: 8] = 8'(k);
      req_wdata_i[8*k +: 8] = 8'h11;
    end
    req_valid_i = 4'b1011;
    gcount = 0;
    n = 0;
    saw2 = 1'b0;
    while (gcount < 4 && n < 600) begin
      @(negedge clk_i);
      n++;
      if (req_ready_o[2]) saw2 = 1'b1;
      if (req_ready_o != '0) begin
        grants[gcount] = req_ready_o;
        gcount++;
        if (gcount == 4) req_valid_i = '0;
      end
    end
    checkOutput("t3 grant count", 32'(gcount), 32'd4);
    checkOutput("t3 grant0", 32'(grants[0]), 32'h1);
    checkOutput("t3 grant1", 32'(grants[1]), 32'h2);
    checkOutput("t3 grant2", 32'(grants[2]), 32'h8);
    checkOutput("t3 grant3", 32'(grants[3]), 32'h1);
    checkOutput("t3 never req2", 32'(saw2), 32'd0);
    n = 0;
    while (!rsp_valid_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput("t3 last rsp id", 32'(rsp_id_o), 32'd0);
    @(negedge clk_i);

    // 4: NACK on the device byte of a read.
    flushLog();
    engNackEn = 1'b1;
    engNackByte = 8'hA0;
    engRdata = 8'h77;
    applyStimulus(1, 1'b1, 7'h50, 8'h22, 8'h00, "t4", rid, st, rd);
    eS(); eW(8'hA0); eP();
    checkSeq("t4");
    checkOutput("t4 rsp id", 32'(rid), 32'd1);
    checkOutput("t4 rsp status", 32'(st), 32'd1);
    checkOutput("t4 rsp rdata", 32'(rd), 32'd0);
    engNackEn = 1'b0;

    // 5: arbitration lost on every START.
    flushLog();
    engArbStart = 1'b1;
    applyStimulus(3, 1'b0, 7'h10, 8'h44, 8'h55, "t5", rid, st, rd);
    eS(); eS(); eS(); eS();
    checkSeq("t5");
    checkOutput("t5 rsp id", 32'(rid), 32'd3);
    checkOutput("t5 rsp status", 32'(st), 32'd2);
    engArbStart = 1'b0;

    // 6: async reset while the register byte is outstanding.
    resetDut(1'b0);
    engHoldAfter = 3;
    req_rnw_i[0] = 1'b0;
    req_dev_i[6:0] = 7'h11;
    req_reg_i[7:0] = 8'h22;
    req_wdata_i[7:0] = 8'h33;
    req_valid_i[0] = 1'b1;
    n = 0;
    while (cmdLog.size() < 3 && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    req_valid_i[0] = 1'b0;
    repeat (3) @(negedge clk_i);
    checkOutput("t6 waiting no cmd", 32'(cmd_valid_o), 32'd0);
    rspBefore = rspCount;
    rst_i = 1'b1;
    #1;
    checkOutput("t6 async outputs", allOut(), 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    engHoldAfter = 0;
    @(negedge clk_i);
    eS(); eW(8'h22); eW(8'h22);
    expQ.delete();
    checkOutput("t6 no stop", 32'(cmdLog.size()), 32'd3);
    engKick = 1'b1;
    repeat (4) @(negedge clk_i);
    checkOutput("t6 stray done", 32'(cmd_valid_o), 32'd0);
    checkOutput("t6 no rsp", 32'(rspCount), 32'(rspBefore));
    flushLog();
    applyStimulus(1, 1'b0, 7'h2A, 8'h01, 8'hFF, "t6b", rid, st, rd);
    eS(); eW(8'h54); eW(8'h01); eW(8'hFF); eP();
    checkSeq("t6b");
    checkOutput("t6b rsp id", 32'(rid), 32'd1);
    checkOutput("t6b rsp status", 32'(st), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
    $finish;
  end

endmodule
